lisa_dmem: RTL and testbench

Data-memory responder on the far end of the LSU memory port. Accepts the LSU's 16-bit byte address, write enable and write data, and returns read data combinationally in the same cycle. Below MMIO_BASE it is a word-addressed RAM. At MMIO_BASE and above it decodes a small register block:
- a console TX FIFO drained by a valid/ready byte stream
- a status/flag register
- a free-running cycle counter

---
 rtl/lisa_pkg.sv | 41 ++++
 rtl/lisa_sync_fifo.sv | 60 ++++++
 rtl/lisa_dmem.sv | 119 +++++++++++
 tb/tb_lisa_dmem.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lisa_pkg.sv
// Shared constants and helpers for the LISA data-memory responder:
// bus widths, MMIO register offsets, STATUS bit layout and address regions.
package lisa_pkg;

  localparam int unsigned LISA_ADDR_W = 16;
  localparam int unsigned LISA_DATA_W = 32;

  localparam logic [LISA_ADDR_W-1:0] OFF_TXDATA = 16'h0000;
  localparam logic [LISA_ADDR_W-1:0] OFF_STATUS = 16'h0004;
  localparam logic [LISA_ADDR_W-1:0] OFF_CYCLES = 16'h0008;

  localparam int unsigned STAT_FULL      = 0;
  localparam int unsigned STAT_EMPTY     = 1;
  localparam int unsigned STAT_OVF       = 2;
  localparam int unsigned STAT_FAULT     = 3;
  localparam int unsigned STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_HOLE,
    REGION_MMIO
  } region_e;

  function automatic logic [LISA_DATA_W-1:0] status_word(
    input logic       full,
    input logic       empty,
    input logic       ovf,
    input logic       fault,
    input logic [7:0] count
  );
    logic [LISA_DATA_W-1:0] w;
    w                          = '0;
    w[STAT_FULL]               = full;
    w[STAT_EMPTY]              = empty;
    w[STAT_OVF]                = ovf;
    w[STAT_FAULT]              = fault;
    w[STAT_COUNT_LSB +: 8]     = count;
    return w;
  endfunction

endpackage

// File: rtl/lisa_sync_fifo.sv
// Single-clock FIFO with occupancy count. Output reads 0 while empty; a push
// into a full FIFO is accepted only when a pop happens in the same cycle.
module lisa_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign count   = count_q;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: storage arrays carry no reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lisa_dmem.sv
// LSU-facing data memory: word RAM below the hole, an unmapped hole that
// faults on write, and an MMIO block with console TX FIFO, STATUS and CYCLES.
module lisa_dmem
  import lisa_pkg::*;
#(
  parameter int unsigned             DEPTH_WORDS = 1024,
  parameter int unsigned             FIFO_DEPTH  = 8,
  parameter logic [LISA_ADDR_W-1:0]  MMIO_BASE   = 16'hFF00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LISA_ADDR_W-1:0] mem_addr,
  input  logic                   mem_write_en,
  input  logic [LISA_DATA_W-1:0] mem_write_data,
  output logic [LISA_DATA_W-1:0] mem_read_data,
  output logic [7:0]             console_data,
  output logic                   console_valid,
  input  logic                   console_ready,
  output logic                   fault
);

  localparam int unsigned              RAM_AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned              CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LISA_ADDR_W:0]     RAM_BYTES = (LISA_ADDR_W+1)'(DEPTH_WORDS * 4);

  logic [LISA_DATA_W-1:0] ram_q [DEPTH_WORDS];
  logic [RAM_AW-1:0]      ram_idx;
  logic [LISA_ADDR_W-1:0] mmio_off;
  region_e                region;

  logic                   wr_ram, wr_tx, wr_status, wr_bad;
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic                   ovf_q, ovf_d, fault_q, fault_d;
  logic [LISA_DATA_W-1:0] cycles_q;

  // MMIO wins over RAM if a large RAM would overlap the register block.
  always_comb begin
    if (mem_addr >= MMIO_BASE)                 region = REGION_MMIO;
    else if ({1'b0, mem_addr} < RAM_BYTES)     region = REGION_RAM;
    else                                       region = REGION_HOLE;
  end

  assign ram_idx  = mem_addr[RAM_AW+1:2];
  assign mmio_off = {mem_addr[LISA_ADDR_W-1:2], 2'b00} - MMIO_BASE;

  assign wr_ram    = mem_write_en && (region == REGION_RAM);
  assign wr_tx     = mem_write_en && (region == REGION_MMIO) && (mmio_off == OFF_TXDATA);
  assign wr_status = mem_write_en && (region == REGION_MMIO) && (mmio_off == OFF_STATUS);
  assign wr_bad    = mem_write_en &&
                     ((region == REGION_HOLE) ||
                      ((region == REGION_MMIO) && (mmio_off != OFF_TXDATA) &&
                       (mmio_off != OFF_STATUS) && (mmio_off != OFF_CYCLES)));

  always_ff @(posedge clk) begin
    if (wr_ram) ram_q[ram_idx] <= mem_write_data;
  end

  always_comb begin
    mem_read_data = '0;
    case (region)
      REGION_RAM: mem_read_data = ram_q[ram_idx];
      REGION_MMIO: begin
        case (mmio_off)
          OFF_STATUS: mem_read_data = status_word(fifo_full, fifo_empty, ovf_q, fault_q,
                                                  8'(fifo_count));
          OFF_CYCLES: mem_read_data = cycles_q;
          default:    mem_read_data = '0;
        endcase
      end
      default: mem_read_data = '0;
    endcase
  end

  assign console_valid = !fifo_empty;
  assign fifo_pop      = console_valid && console_ready;

  lisa_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_tx),
    .pop   (fifo_pop),
    .din   (mem_write_data[7:0]),
    .dout  (console_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // W1C clears are applied first so a same-cycle set event overrides them.
  always_comb begin
    ovf_d   = ovf_q;
    fault_d = fault_q;
    if (wr_status) begin
      if (mem_write_data[STAT_OVF])   ovf_d   = 1'b0;
      if (mem_write_data[STAT_FAULT]) fault_d = 1'b0;
    end
    if (wr_tx && fifo_full && !fifo_pop) ovf_d   = 1'b1;
    if (wr_bad)                          fault_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q    <= 1'b0;
      fault_q  <= 1'b0;
      cycles_q <= '0;
    end else begin
      ovf_q    <= ovf_d;
      fault_q  <= fault_d;
      cycles_q <= cycles_q + 1'b1;
    end
  end

  assign fault = fault_q;

endmodule

// File: tb/tb_lisa_dmem.sv
// Self-checking bench for lisa_dmem: a transaction-level model (array RAM,
// byte queue, flag bits, counter) checked every cycle, plus literal checkpoints.
module tb_lisa_dmem;

  localparam logic [15:0] TX = 16'hFF00;
  localparam logic [15:0] ST = 16'hFF04;
  localparam logic [15:0] CY = 16'hFF08;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [7:0]  console_data;
  logic        console_valid;
  logic        console_ready;
  logic        fault;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] ram_m [1024];
  bit          ram_known [1024];
  logic [7:0]  q_m [$];
  bit          ovf_m, fault_m;
  logic [31:0] cyc_m;

  lisa_dmem #(
    .DEPTH_WORDS (1024),
    .FIFO_DEPTH  (8),
    .MMIO_BASE   (16'hFF00)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .console_data   (console_data),
    .console_valid  (console_valid),
    .console_ready  (console_ready),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected read value from the model; known=0 where RAM was never written.
  task automatic model_read(input logic [15:0] a, output logic [31:0] v, output bit known);
    logic [15:0] off;
    known = 1'b1;
    v     = 32'h0;
    if (a >= TX) begin
      off = (a & 16'hFFFC) - TX;
      if (off == 16'h4)
        v = (32'(q_m.size()) << 8) | (32'(fault_m) << 3) | (32'(ovf_m) << 2) |
            (32'(q_m.size() == 0) << 1) | 32'(q_m.size() == 8);
      else if (off == 16'h8)
        v = cyc_m;
    end else if (a < 16'd4096) begin
      known = ram_known[a[11:2]];
      v     = ram_m[a[11:2]];
    end
  endtask

  task automatic model_step();
    int          n;
    bit          pop, push;
    logic [15:0] off;
    n    = q_m.size();
    off  = (mem_addr & 16'hFFFC) - TX;
    pop  = (n > 0) && console_ready;
    push = mem_write_en && (mem_addr >= TX) && (off == 16'h0);
    if (mem_write_en) begin
      if (mem_addr >= TX) begin
        if (off == 16'h4) begin
          if (mem_write_data[2]) ovf_m   = 1'b0;
          if (mem_write_data[3]) fault_m = 1'b0;
        end else if (off != 16'h0 && off != 16'h8) begin
          fault_m = 1'b1;
        end
      end else if (mem_addr < 16'd4096) begin
        ram_m[mem_addr[11:2]]     = mem_write_data;
        ram_known[mem_addr[11:2]] = 1'b1;
      end else begin
        fault_m = 1'b1;
      end
    end
    if (push && n == 8 && !pop) ovf_m = 1'b1;
    if (pop) void'(q_m.pop_front());
    if (push && (n < 8 || pop)) q_m.push_back(mem_write_data[7:0]);
    cyc_m = cyc_m + 32'd1;
  endtask

  // Inputs change just after posedge, so the negedge sees the values the next edge will use.
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    bit          known;
    if (!rst_n) begin
      q_m.delete();
      ovf_m   = 1'b0;
      fault_m = 1'b0;
      cyc_m   = 32'h0;
      check("rst_valid", 32'(console_valid), 32'h0);
      check("rst_data",  32'(console_data),  32'h0);
      check("rst_fault", 32'(fault),         32'h0);
    end else begin
      model_read(mem_addr, exp_rd, known);
      if (known) check("model_rdata", mem_read_data, exp_rd);
      check("model_valid", 32'(console_valid), 32'(q_m.size() != 0));
      check("model_data",  32'(console_data),  32'(q_m.size() != 0 ? q_m[0] : 8'h00));
      check("model_fault", 32'(fault),         32'(fault_m));
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    mem_addr       = a;
    mem_write_en   = 1'b1;
    mem_write_data = d;
    tick();
    mem_write_en   = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [31:0] exp);
    mem_addr     = a;
    mem_write_en = 1'b0;
    #1 check(name, mem_read_data, exp);
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] c5, c15;
    logic [7:0]  exp_seq [8];

    rst_n          = 1'b0;
    mem_addr       = 16'h0010;
    mem_write_en   = 1'b0;
    mem_write_data = 32'h0;
    console_ready  = 1'b0;
    repeat (3) tick();
    check("reset_valid", 32'(console_valid), 32'h0);
    check("reset_fault", 32'(fault), 32'h0);
    rst_n = 1'b1;

    // Cycle counter: value k after k edges from release.
    mem_addr = CY;
    repeat (5) tick();
    c5 = mem_read_data;
    check("cycles_at5", c5, 32'd5);
    repeat (10) tick();
    c15 = mem_read_data;
    check("cycles_delta", c15 - c5, 32'd10);

    // RAM write / read-before-write.
    wr(16'h0010, 32'h1234_5678);
    mem_addr       = 16'h0010;
    mem_write_en   = 1'b1;
    mem_write_data = 32'hDEAD_BEEF;
    #1 check("ram_same_cycle_old", mem_read_data, 32'h1234_5678);
    tick();
    mem_write_en = 1'b0;
    rd_check("ram_read_0010", 16'h0010, 32'hDEAD_BEEF);
    rd_check("ram_read_0013", 16'h0013, 32'hDEAD_BEEF);
    tick();

    // Hole write faults; W1C clears it.
    wr(16'h1000, 32'h11);
    check("hole_fault_set", 32'(fault), 32'h1);
    rd_check("hole_read", 16'h1000, 32'h0);
    tick();
    wr(ST, 32'h8);
    check("fault_cleared", 32'(fault), 32'h0);

    // Overfill with ready low.
    for (int i = 0; i < 9; i++) wr(TX, 32'h41 + 32'(i));
    rd_check("status_full_ovf", ST, 32'h0000_0805);
    console_ready = 1'b1;
    mem_addr      = 16'h0010;
    for (int i = 0; i < 8; i++) begin
      check("drain_order", 32'(console_data), 32'h41 + 32'(i));
      tick();
    end
    check("drained_valid", 32'(console_valid), 32'h0);
    rd_check("status_empty_ovf", ST, 32'h0000_0006);
    tick();
    wr(ST, 32'h4);
    rd_check("status_cleared", ST, 32'h0000_0002);
    tick();

    // Push into a full FIFO while it pops: accepted, no overflow.
    console_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(TX, 32'h61 + 32'(i));
    rd_check("status_full", ST, 32'h0000_0801);
    console_ready = 1'b1;
    wr(TX, 32'h5A);
    rd_check("status_push_pop_full", ST, 32'h0000_0801);
    for (int i = 0; i < 7; i++) exp_seq[i] = 8'h62 + 8'(i);
    exp_seq[7] = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      check("full_pushpop_order", 32'(console_data), 32'(exp_seq[i]));
      tick();
    end
    rd_check("status_after_5a", ST, 32'h0000_0002);
    tick();

    // Counter wrap.
    mem_addr = CY;
    force dut.cycles_q = 32'hFFFF_FFFE;
    #1 release dut.cycles_q;
    cyc_m = 32'hFFFF_FFFE;
    #1 check("cycles_forced", mem_read_data, 32'hFFFF_FFFE);
    tick();
    tick();
    check("cycles_wrap", mem_read_data, 32'h0);

    // Reset mid-drain.
    console_ready = 1'b0;
    wr(16'h2000, 32'h0);
    for (int i = 0; i < 5; i++) wr(TX, 32'h71 + 32'(i));
    console_ready = 1'b1;
    mem_addr      = 16'h0010;
    tick();
    tick();
    check("pre_reset_head", 32'(console_data), 32'h73);
    check("pre_reset_fault", 32'(fault), 32'h1);
    #2 rst_n = 1'b0;
    #1 check("async_valid_drop", 32'(console_valid), 32'h0);
    check("async_fault_drop", 32'(fault), 32'h0);
    tick();
    rst_n         = 1'b1;
    console_ready = 1'b0;
    rd_check("post_reset_cycles", CY, 32'h0);
    rd_check("post_reset_status", ST, 32'h0000_0002);
    rd_check("post_reset_ram", 16'h0010, 32'hDEAD_BEEF);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
